// File: rtl/stochastic_pkg.sv
// stochastic_pkg: shared state encoding, LFSR width and value widening helper for stochastic_stream_ctrl
package stochastic_pkg;
    localparam int LFSR_WIDTH = 20;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Keeps only the low bw bits so a narrower value compares as an unsigned LFSR-wide number
    function automatic logic [LFSR_WIDTH-1:0] zext_value(input logic [LFSR_WIDTH-1:0] v, input int bw);
        return v & ((LFSR_WIDTH'(1) << bw) - LFSR_WIDTH'(1));
    endfunction
endpackage

// File: rtl/stochastic_stream_ctrl_if.sv
// stochastic_stream_ctrl_if: request/stream handshake bundle; abort/aborted exist only with STREAM_ABORT_EN
interface stochastic_stream_ctrl_if #(
    parameter int BITWIDTH  = 20,
    parameter int LEN_WIDTH = 16
);
    logic                 start;
    logic [BITWIDTH-1:0]  value;
    logic                 is_negative;
    logic [LEN_WIDTH-1:0] length;
    logic                 ready;
    logic                 busy;
    logic                 valid;
    logic                 out_p;
    logic                 out_m;
    logic                 done;
    logic [LEN_WIDTH-1:0] ones_count;
`ifdef STREAM_ABORT_EN
    logic                 abort;
    logic                 aborted;
`endif

    modport master (
        output start, value, is_negative, length, ready,
`ifdef STREAM_ABORT_EN
        output abort, input aborted,
`endif
        input busy, valid, out_p, out_m, done, ones_count
    );

    modport slave (
        input start, value, is_negative, length, ready,
`ifdef STREAM_ABORT_EN
        input abort, output aborted,
`endif
        output busy, valid, out_p, out_m, done, ones_count
    );
endinterface

// File: rtl/stochastic_stream_ctrl_lfsr.sv
// fibonacci_lfsr_20: free-running 20-bit Fibonacci LFSR (taps 20,17), restarts from a fixed seed on reset
module fibonacci_lfsr_20 (
    input  logic        clk,
    input  logic        rst_n,
    output logic [19:0] lfsr_r
);
    // Shift left every cycle, feeding back the XOR of the two tap bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_r <= 20'hA5C3E;
        else        lfsr_r <= {lfsr_r[18:0], lfsr_r[19] ^ lfsr_r[16]};
    end
endmodule

// File: rtl/stochastic_stream_ctrl.sv
// stochastic_stream_ctrl: emits one counted, back-pressured stochastic bitstream per start; STREAM_ABORT_EN adds abort
module stochastic_stream_ctrl
    import stochastic_pkg::*;
#(
    parameter int BITWIDTH  = 20,
    parameter int LEN_WIDTH = 16
) (
    input logic                     CLK,
    input logic                     nRST,
    stochastic_stream_ctrl_if.slave s
);
    state_t                state_q, state_d;
    logic [LFSR_WIDTH-1:0] value_q, value_d, lfsr_r;
    logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d, ones_q, ones_d;
    logic                  neg_q, neg_d, valid_q, valid_d, out_p_q, out_p_d, out_m_q, out_m_d;
    logic                  done_q, done_d, busy_q, busy_d;
    logic                  abort_w, xfer, last, bit_w;

    fibonacci_lfsr_20 u_lfsr (.clk(CLK), .rst_n(nRST), .lfsr_r(lfsr_r));

`ifdef STREAM_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_w   = s.abort && state_q == RUN;
    assign s.aborted = aborted_q;
`else
    assign abort_w = 1'b0;
`endif

    assign bit_w = lfsr_r < value_q;
    assign xfer  = valid_q && s.ready && !abort_w;
    assign last  = cnt_q + LEN_WIDTH'(1) == len_q;

    assign s.busy       = busy_q;
    assign s.valid      = valid_q;
    assign s.out_p      = out_p_q;
    assign s.out_m      = out_m_q;
    assign s.done       = done_q;
    assign s.ones_count = ones_q;

    // Next-state, latching, bit generation and counting; busy/done follow the state one cycle later
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        neg_d   = neg_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        valid_d = valid_q;
        out_p_d = out_p_q;
        out_m_d = out_m_q;
        done_d  = state_q == DONE;
        busy_d  = state_q != IDLE;
`ifdef STREAM_ABORT_EN
        aborted_d = aborted_q | abort_w;
`endif
        if (state_q == IDLE) begin
            if (s.start && !busy_q) begin
                value_d = zext_value(LFSR_WIDTH'(s.value), BITWIDTH);
                neg_d   = s.is_negative;
                len_d   = s.length;
                cnt_d   = '0;
                ones_d  = '0;
                state_d = s.length == '0 ? DONE : RUN;
`ifdef STREAM_ABORT_EN
                aborted_d = 1'b0;
`endif
            end
        end else if (state_q == RUN) begin
            if (xfer) begin
                cnt_d  = cnt_q + LEN_WIDTH'(1);
                ones_d = ones_q + LEN_WIDTH'(out_p_q | out_m_q);
            end
            if (abort_w || (xfer && last)) begin
                state_d = DONE;
                valid_d = 1'b0;
                out_p_d = 1'b0;
                out_m_d = 1'b0;
            end else if (!valid_q || xfer) begin
                valid_d = 1'b1;
                out_p_d = bit_w && !neg_q;
                out_m_d = bit_w && neg_q;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // State and output registers; reset abandons any stream without a done pulse
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            value_q <= '0;
            neg_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            ones_q  <= '0;
            valid_q <= 1'b0;
            out_p_q <= 1'b0;
            out_m_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef STREAM_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            neg_q   <= neg_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
            out_p_q <= out_p_d;
            out_m_q <= out_m_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef STREAM_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end
endmodule

// File: tb/tb_stochastic_stream_ctrl.sv
// tb_stochastic_stream_ctrl: table of stream requests checked bit-by-bit against an LFSR reference scoreboard
module tb_stochastic_stream_ctrl;
    localparam logic [19:0] SEED = 20'hA5C3E;

    typedef struct {
        logic [19:0] v;
        logic        neg;
        int          len;
        int          mode;
        int          min1;
        int          max1;
        int          exp_valid;
        int          exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [19:0] m;
    int          checks = 0;
    int          failures = 0;
    bit          sb[$];
    bit          q_bits[$];
    bit          ref_bits[$];

    stochastic_stream_ctrl_if #(.BITWIDTH(20), .LEN_WIDTH(16)) bus ();
    stochastic_stream_ctrl #(.BITWIDTH(20), .LEN_WIDTH(16)) dut (.CLK(clk), .nRST(rst_n), .s(bus));

    always #5 clk = ~clk;

    // Reference LFSR: x^20 + x^17 + 1, same seed and reset as the design's generator
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= SEED;
        else        m <= {m[18:0], m[19] ^ m[16]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'({bus.busy, bus.valid, bus.out_p, bus.out_m, bus.done, bus.ones_count}), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_quiet", 32'({bus.done, bus.valid, bus.busy}), 0);
        end
    endtask

    task automatic run_stream(input logic [19:0] v, input logic neg, input int len, input int mode,
                              input int rst_at, input int restart_at, input int abort_at,
                              output int ones, output int nvalid, output int xfers, output int done_cyc);
        int cyc;
        int done_n;
        bit stall, held, busy_after, aborting, abort_now;
        ones = 0; nvalid = 0; xfers = 0; done_cyc = -1; done_n = 0;
        stall = 0; held = 0; busy_after = 1; aborting = 0;
        sb.delete();
        q_bits.delete();
        @(negedge clk);
        bus.start = 1; bus.value = v; bus.is_negative = neg; bus.length = 16'(len); bus.ready = 1;
        @(negedge clk);
        bus.start = 0;
        if (len > 0) sb.push_back(m < v);
        for (cyc = 1; cyc <= 4 * len + 20 && (done_cyc < 0 || cyc <= done_cyc + 1); cyc++) begin
            @(negedge clk);
            bus.start = 0;
            abort_now = 0;
            bus.ready = mode == 0 || (cyc - 1) % 4 == 0 || (cyc - 1) % 4 == 3;
            check("idle_channel", 32'(neg ? bus.out_p : bus.out_m), 0);
            if (stall) check("stall_hold", 32'({bus.valid, bus.out_p | bus.out_m}), 32'({1'b1, held}));
            if (bus.done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("busy_at_done", 32'(bus.busy), 1);
                    check("ones_count", 32'(bus.ones_count), 32'(ones));
`ifdef STREAM_ABORT_EN
                    check("aborted_flag", 32'(bus.aborted), 32'(abort_at > 0));
`endif
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = bus.busy;
            if (bus.valid) begin
                nvalid++;
                if (nvalid == 1) check("first_valid_cyc", 32'(cyc), 1);
            end
            if (rst_at > 0 && bus.valid && xfers == rst_at - 1) begin
                do_reset();
                return;
            end
            if (restart_at > 0 && xfers == restart_at) begin
                bus.start = 1; bus.value = 0; bus.length = 5;
            end
`ifdef STREAM_ABORT_EN
            bus.abort = 0;
            if (abort_at > 0 && bus.valid && xfers == abort_at - 1 && !aborting) begin
                bus.abort = 1;
                aborting = 1;
                abort_now = 1;
            end
`endif
            held = bus.out_p | bus.out_m;
            stall = bus.valid && !bus.ready;
            if (bus.valid && bus.ready && !abort_now && !aborting) begin
                check("bit", 32'(held), sb.size() > 0 ? 32'(sb.pop_front()) : 32'hDEAD);
                ones += int'(held);
                q_bits.push_back(held);
                xfers++;
                if (xfers < len) sb.push_back(m < v);
            end
        end
        check("done_pulses", 32'(done_n), 1);
        check("busy_after_done", 32'(busy_after), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int ones, nv, xf, dc, bad;
        bus.start = 0; bus.value = 0; bus.is_negative = 0; bus.length = 0; bus.ready = 0;
`ifdef STREAM_ABORT_EN
        bus.abort = 0;
`endif
        tbl[0] = '{20'h00000, 1'b0, 0,    0, 0,   0,    0,    1};
        tbl[1] = '{20'h00000, 1'b0, 100,  0, 0,   0,    100,  102};
        tbl[2] = '{20'h80000, 1'b1, 1000, 0, 450, 550,  1000, 1002};
        tbl[3] = '{20'h80000, 1'b1, 1000, 1, 450, 550,  -1,   -1};
        tbl[4] = '{20'hFFFFF, 1'b0, 64,   0, 63,  64,   64,   66};
        tbl[5] = '{20'h30000, 1'b0, 7,    0, 0,   7,    7,    9};
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_stream(tbl[i].v, tbl[i].neg, tbl[i].len, tbl[i].mode, 0, 0, 0, ones, nv, xf, dc);
            check($sformatf("xfers[%0d]", i), 32'(xf), 32'(tbl[i].len));
            check($sformatf("ones_range[%0d]", i), 32'(ones >= tbl[i].min1 && ones <= tbl[i].max1), 1);
            if (tbl[i].exp_valid >= 0) check($sformatf("valid_cycles[%0d]", i), 32'(nv), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_done >= 0) check($sformatf("done_cycle[%0d]", i), 32'(dc), 32'(tbl[i].exp_done));
        end

        @(negedge clk);
        do_reset();
        run_stream(20'h80000, 1'b0, 200, 0, 0, 0, 0, ones, nv, xf, dc);
        ref_bits = q_bits;
        @(negedge clk);
        do_reset();
        run_stream(20'h80000, 1'b0, 200, 0, 37, 10, 0, ones, nv, xf, dc);
        check("xfers_before_reset", 32'(xf), 36);
        check("no_done_before_reset", 32'(dc), 32'hFFFFFFFF);
        run_stream(20'h80000, 1'b0, 200, 0, 0, 0, 0, ones, nv, xf, dc);
        check("restart_len", 32'(q_bits.size()), 32'(ref_bits.size()));
        bad = 0;
        for (int i = 0; i < q_bits.size() && i < ref_bits.size(); i++) bad += int'(q_bits[i] != ref_bits[i]);
        check("restart_stream_match", 32'(bad), 0);

`ifdef STREAM_ABORT_EN
        run_stream(20'h80000, 1'b0, 500, 0, 0, 0, 50, ones, nv, xf, dc);
        check("abort_xfers", 32'(xf), 49);
        run_stream(20'h80000, 1'b0, 3, 0, 0, 0, 0, ones, nv, xf, dc);
        check("post_abort_xfers", 32'(xf), 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stochastic_stream_ctrl.md
Name: stochastic_stream_ctrl

Overview:
- Sequencer that issues one finite-length stochastic bitstream per request, using a locally owned 20-bit Fibonacci LFSR (fibonacci_lfsr_20).
- Latches a value, sign and stream length on a start handshake, then emits exactly `length` valid bits under downstream back-pressure.
- Counts emitted ones and signals completion.
- Sits between a host/test harness and stochastic arithmetic blocks that need bounded, counted bitstreams rather than free-running ones.

Parameters:
- BITWIDTH, 20, width of value compared against the LFSR; must be ≤ 20; value is zero-extended to 20 bits.
- LEN_WIDTH, 16, width of the length and ones-count fields.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- start  in  1  request a new stream; accepted only in IDLE.
- value  in  BITWIDTH  probability numerator; sampled on accept.
- is_negative  in  1  sign; sampled on accept.
- length  in  LEN_WIDTH  number of bits to emit; sampled on accept.
- ready  in  1  downstream accepts the current bit.
- busy  out  1  high in RUN and DONE.
- valid  out  1  current out_p/out_m bit is valid.
- out_p  out  1  positive-channel bit.
- out_m  out  1  negative-channel bit.
- done  out  1  one-cycle completion pulse.
- ones_count  out  LEN_WIDTH  number of emitted 1 bits on the active channel.

Behaviour:
- Reset:
  - Asynchronous, active-low; all outputs 0, state IDLE, latched registers 0.
  - Reset mid-stream abandons the stream immediately, with no done pulse.
  - The LFSR shares nRST and restarts from its seed.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches value, is_negative and length; clears ones_count and the emitted counter.
  - If length==0, go to DONE; else go to RUN.
- RUN:
  - Bit generation: a bit is registered from (lfsr_r < value_q), routed to out_p when is_negative_q=0, to out_m otherwise. The unused channel is held at 0.
  - valid rises the first cycle after entering RUN, so first-bit latency is 2 cycles from the start edge.
  - Transfer: occurs on a cycle with valid & ready. The emitted counter increments; ones_count increments if the transferred bit is 1. A new bit is registered the next cycle.
  - Stall: while valid & !ready, out_p/out_m/valid hold. The LFSR keeps free-running; its samples are discarded.
  - Exit: the transfer of bit number `length` moves to DONE. valid drops the next cycle.
- DONE:
  - done=1 for exactly one cycle; busy=1; then IDLE.
  - ones_count holds its final value until the next accepted start.
- start while busy is ignored; there is no queueing.
- Widths and boundaries:
  - Comparison is unsigned and 20 bits wide.
  - value=0 produces all zeros.
  - value=2^BITWIDTH-1 with BITWIDTH=20 produces all ones except when the LFSR is all-ones.
  - ones_count ≤ length, so it cannot overflow.
  - length=2^LEN_WIDTH-1 is legal.

Optional Feature:
- STREAM_ABORT_EN defined:
  - Adds input abort (1) and output aborted (1).
  - abort=1 in RUN goes to DONE next cycle; no further transfers, including a transfer coinciding with abort.
  - done pulses with aborted=1 and ones_count holding the partial count.
  - aborted clears on the next accepted start; abort is ignored outside RUN.
- Not defined: ports absent; streams always run to completion.

Decomposition:
- Shared package stochastic_pkg:
  - state enum (IDLE/RUN/DONE).
  - LFSR_WIDTH=20 constant.
  - Zero-extension helper function for value.
- Natural sub-module:
  - The existing fibonacci_lfsr_20, instantiated unchanged.
  - No other sub-modules; the FSM and counters live in this block.

Test Plan:
- length=0, start pulse → done pulse 2 cycles after the start edge, valid never high, ones_count=0.
- value=0, length=100, ready=1 → 100 valid bits all 0, done once, ones_count=0, busy low after done.
- value=2^19 (p≈0.5), is_negative=1, length=1000, ready=1:
  - out_p always 0.
  - ones_count equals the golden LFSR model count and lies within 450..550.
  - valid high exactly 1000 cycles.
- Same stream with ready toggling 1,0,0,1…:
  - bits held stable during stalls.
  - exactly 1000 transfers.
  - ones_count matches the number of 1s sampled on transfer cycles.
- start asserted again mid-RUN, then nRST low for 1 cycle at bit 37 of length 200:
  - second start ignored.
  - all outputs 0 immediately, no done pulse.
  - a new start afterwards produces a stream identical to a fresh post-reset run.
- With STREAM_ABORT_EN: abort at transfer 50 of length 500 → no transfer that cycle, done+aborted pulse next cycle, ones_count equals ones in the first 49 transfers.
